// File: rtl/ov7670_pkg.sv
// Shared OV7670 types and default timing constants for the frame source and the capture benches.
package ov7670_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } state_t;

    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_BPP         = 2;
    localparam int DEF_H_BLANK     = 144;
    localparam int DEF_VSYNC_LINES = 3;
    localparam int DEF_V_BACK      = 17;
    localparam int DEF_V_FRONT     = 10;
    localparam int DEF_ADDR_W      = 19;

    // Bits needed to hold values 0..max_value, never less than one.
    function automatic int cnt_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ov7670_timing_counter.sv
// Byte position within a line and line position within the current frame phase.
module ov7670_timing_counter #(
    parameter int LINE = 10,
    parameter int HW   = 4,
    parameter int LW   = 1
) (
    input  logic          pclk,
    input  logic          rst_n,
    input  logic          run,
    input  logic [LW-1:0] phase_last,
    output logic [HW-1:0] h_nxt,
    output logic [LW-1:0] line_nxt,
    output logic          phase_end
);

    logic [HW-1:0] h_cnt_r;
    logic [LW-1:0] line_cnt_r;
    logic          line_end_s;

    // Next-position logic; counters sit at zero while not running.
    always_comb begin
        line_end_s = (h_cnt_r == HW'(LINE - 1));
        phase_end  = line_end_s && (line_cnt_r == phase_last);
        h_nxt      = h_cnt_r;
        line_nxt   = line_cnt_r;
        if (!run) begin
            h_nxt    = '0;
            line_nxt = '0;
        end else if (line_end_s) begin
            h_nxt    = '0;
            line_nxt = phase_end ? '0 : line_cnt_r + LW'(1);
        end else begin
            h_nxt    = h_cnt_r + HW'(1);
            line_nxt = line_cnt_r;
        end
    end

    // Position registers.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r    <= '0;
            line_cnt_r <= '0;
        end else begin
            h_cnt_r    <= h_nxt;
            line_cnt_r <= line_nxt;
        end
    end

endmodule

// File: rtl/ov7670_frame_source.sv
// OV7670 sensor emulator: streams a frame buffer as vsync/href/dout exactly as the camera does.
module ov7670_frame_source
    import ov7670_pkg::*;
#(
    parameter int         H_ACTIVE    = DEF_H_ACTIVE,
    parameter int         V_ACTIVE    = DEF_V_ACTIVE,
    parameter int         BPP         = DEF_BPP,
    parameter int         H_BLANK     = DEF_H_BLANK,
    parameter int         VSYNC_LINES = DEF_VSYNC_LINES,
    parameter int         V_BACK      = DEF_V_BACK,
    parameter int         V_FRONT     = DEF_V_FRONT,
    parameter logic [7:0] PAD_BYTE    = 8'h00,
    parameter int         ADDR_W      = DEF_ADDR_W
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              vsync,
    output logic              href,
    output logic [7:0]        dout,
    output logic              busy,
    output logic              frame_done
);

    localparam int HBYTES = H_ACTIVE * BPP;
    localparam int LINE   = HBYTES + H_BLANK;
    localparam int PIX    = H_ACTIVE * V_ACTIVE;
    localparam int HW     = cnt_width(LINE - 1);
    localparam int LW     = cnt_width(max4(VSYNC_LINES, V_BACK, V_ACTIVE, V_FRONT) - 1);

    state_t          state_r, state_nxt_s;
    logic [HW-1:0]   h_nxt_s;
    logic [LW-1:0]   line_nxt_s, phase_last_s;
    logic            phase_end_s;
    logic            href_nxt_s, rd_en_nxt_s, fd_nxt_s, next_line_active_s, act2_s;
    logic [7:0]      dout_nxt_s;
    logic            rd_q_r;
    logic [ADDR_W-1:0] ptr_r;
    int              h2_s, pos2_s;

    ov7670_timing_counter #(.LINE(LINE), .HW(HW), .LW(LW)) u_timing (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .run        (state_r != ST_IDLE),
        .phase_last (phase_last_s),
        .h_nxt      (h_nxt_s),
        .line_nxt   (line_nxt_s),
        .phase_end  (phase_end_s)
    );

    // Phase length and state sequencing; en only matters at frame boundaries.
    always_comb begin
        phase_last_s = '0;
        state_nxt_s  = state_r;
        case (state_r)
            ST_IDLE: begin
                state_nxt_s = en ? ST_VSYNC : ST_IDLE;
            end
            ST_VSYNC: begin
                phase_last_s = LW'(VSYNC_LINES - 1);
                state_nxt_s  = phase_end_s ? ST_VBACK : ST_VSYNC;
            end
            ST_VBACK: begin
                phase_last_s = LW'(V_BACK - 1);
                state_nxt_s  = phase_end_s ? ST_ACTIVE : ST_VBACK;
            end
            ST_ACTIVE: begin
                phase_last_s = LW'(V_ACTIVE - 1);
                state_nxt_s  = phase_end_s ? ST_VFRONT : ST_ACTIVE;
            end
            ST_VFRONT: begin
                phase_last_s = LW'(V_FRONT - 1);
                if (phase_end_s) state_nxt_s = en ? ST_VSYNC : ST_IDLE;
                else             state_nxt_s = ST_VFRONT;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Decode the upcoming cycle; a read is issued two cycles ahead of its pixel's first byte.
    always_comb begin
        href_nxt_s = (state_nxt_s == ST_ACTIVE) && (int'(h_nxt_s) < HBYTES);
        fd_nxt_s   = (state_nxt_s == ST_VFRONT) && (h_nxt_s == HW'(LINE - 1))
                     && (line_nxt_s == LW'(V_FRONT - 1));
        next_line_active_s = ((state_nxt_s == ST_ACTIVE) && (line_nxt_s != LW'(V_ACTIVE - 1)))
                          || ((state_nxt_s == ST_VBACK) && (line_nxt_s == LW'(V_BACK - 1)));
        h2_s = int'(h_nxt_s) + 2;
        if (h2_s >= LINE) begin
            pos2_s = h2_s - LINE;
            act2_s = next_line_active_s;
        end else begin
            pos2_s = h2_s;
            act2_s = (state_nxt_s == ST_ACTIVE);
        end
        rd_en_nxt_s = act2_s && (pos2_s < HBYTES) && ((pos2_s % BPP) == 0);
        if (rd_q_r)          dout_nxt_s = rd_data;
        else if (href_nxt_s) dout_nxt_s = PAD_BYTE;
        else                 dout_nxt_s = 8'h00;
    end

    // State, read pipeline and registered bus outputs.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            vsync      <= 1'b0;
            href       <= 1'b0;
            dout       <= 8'h00;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            rd_q_r     <= 1'b0;
            ptr_r      <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            vsync      <= (state_nxt_s == ST_VSYNC);
            href       <= href_nxt_s;
            dout       <= dout_nxt_s;
            rd_en      <= rd_en_nxt_s;
            rd_q_r     <= rd_en;
            busy       <= (state_nxt_s != ST_IDLE);
            frame_done <= fd_nxt_s;
            if (rd_en_nxt_s) begin
                rd_addr <= ptr_r;
                ptr_r   <= (ptr_r == ADDR_W'(PIX - 1)) ? '0 : ptr_r + ADDR_W'(1);
            end else begin
                rd_addr <= rd_addr;
                ptr_r   <= ptr_r;
            end
        end
    end

endmodule

// File: tb/tb_ov7670_frame_source.sv
// Self-checking bench: frame-position model of the OV7670 waveform plus a few pinned literals.
module tb_ov7670_frame_source;

    localparam int H_A = 4, V_A = 3, BPP = 2, H_B = 2, VSL = 1, VB = 1, VF = 1;
    localparam int LINE   = H_A * BPP + H_B;              // 10
    localparam int VS_END = VSL * LINE;                   // 10
    localparam int ACT0   = (VSL + VB) * LINE + 1;        // 21
    localparam int ACT_E  = (VSL + VB + V_A) * LINE;      // 50
    localparam int FRAME  = (VSL + VB + V_A + VF) * LINE; // 60
    localparam int NPIX   = H_A * V_A;                    // 12

    logic        pclk = 1'b0;
    logic        rst_n, en, rd_en, vsync, href, busy, frame_done;
    logic [18:0] rd_addr;
    logic [7:0]  rd_data, dout;
    logic [7:0]  mem [0:NPIX-1];

    int checks = 0, failures = 0;
    int t;        // model frame position: 0 idle, 1..FRAME within a frame
    int addr_m;   // model rd_addr (holds between reads)
    int cap_k;
    logic [7:0] capq [$];

    ov7670_frame_source #(
        .H_ACTIVE(H_A), .V_ACTIVE(V_A), .BPP(BPP), .H_BLANK(H_B), .VSYNC_LINES(VSL),
        .V_BACK(VB), .V_FRONT(VF), .PAD_BYTE(8'h00), .ADDR_W(19)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .en(en), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .vsync(vsync), .href(href), .dout(dout), .busy(busy),
        .frame_done(frame_done)
    );

    always #5 pclk = ~pclk;

    function automatic bit href_at(input int tt);
        return (tt >= ACT0) && (tt <= ACT_E) && (((tt - ACT0) % LINE) < H_A * BPP);
    endfunction

    function automatic bit byte0_at(input int tt);
        return href_at(tt) && ((((tt - ACT0) % LINE) % BPP) == 0);
    endfunction

    function automatic int pix_at(input int tt);
        return ((tt - ACT0) / LINE) * H_A + ((tt - ACT0) % LINE) / BPP;
    endfunction

    function automatic int next_t(input int tt, input logic e);
        if (tt == 0 || tt == FRAME) return e ? 1 : 0;
        return tt + 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d actual=%0h expected=%0h", nm, t, act, exp);
        end
    endtask

    // Synchronous frame buffer, one-cycle read latency.
    always @(posedge pclk) begin
        if (rd_en) rd_data <= (rd_addr < 19'd12) ? mem[rd_addr[3:0]] : 8'hEE;
    end

    // Frame-position model.
    always @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            t      <= 0;
            addr_m <= 0;
        end else begin
            t <= next_t(t, en);
            if (byte0_at(next_t(t, en) + 2)) addr_m <= pix_at(next_t(t, en) + 2);
        end
    end

    // Per-cycle comparison, literal pins and byte capture.
    always @(negedge pclk) begin
        if (!rst_n) begin
            capq.delete();
            cap_k <= 0;
        end else begin
            chk("vsync", vsync, (t >= 1) && (t <= VS_END));
            chk("href", href, href_at(t));
            chk("dout", dout, byte0_at(t) ? mem[pix_at(t)] : 8'h00);
            chk("rd_en", rd_en, byte0_at(t + 2));
            chk("rd_addr", rd_addr, addr_m);
            chk("busy", busy, t != 0);
            chk("frame_done", frame_done, t == FRAME);
            chk("vsync_and_href", vsync & href, 1'b0);
            if (t == 10) chk("lit_vsync_last", vsync, 1'b1);
            if (t == 11) chk("lit_vsync_off", vsync, 1'b0);
            if (t == 19) chk("lit_first_read", {rd_en, rd_addr}, {1'b1, 19'd0});
            if (t == 21) chk("lit_pix0", {href, dout}, {1'b1, 8'h10});
            if (t == 23) chk("lit_pix1", dout, 8'h11);
            if (t == 29) chk("lit_hblank", href, 1'b0);
            if (t == 45) chk("lit_last_read", {rd_en, rd_addr}, {1'b1, 19'd11});
            if (t == 47) chk("lit_pix11", dout, 8'h1B);
            if (t == 60) chk("lit_frame_done", frame_done, 1'b1);
            if (href) begin
                if (cap_k == 0) capq.push_back(dout);
                cap_k <= (cap_k + 1) % BPP;
            end
            if (t == FRAME) begin
                chk("cap_count", capq.size(), NPIX);
                for (int i = 0; i < NPIX; i++)
                    if (i < capq.size()) chk("cap_byte", capq[i], mem[i]);
                capq.delete();
            end
        end
    end

    initial begin
        for (int i = 0; i < NPIX; i++) mem[i] = 8'h10 + 8'(i);
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) @(posedge pclk);
        #2;
        chk("rst_vsync", vsync, 1'b0);
        chk("rst_href", href, 1'b0);
        chk("rst_dout", dout, 8'h00);
        chk("rst_rd_en", rd_en, 1'b0);
        chk("rst_rd_addr", rd_addr, 19'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(posedge pclk);
        #2 en = 1'b1;
        // Three full back-to-back frames, then drop en mid-ACTIVE of the fourth.
        repeat (3 * FRAME + 30) @(posedge pclk);
        #2 en = 1'b0;
        repeat (FRAME) @(posedge pclk);
        #2 en = 1'b1;
        repeat (23) @(posedge pclk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_href", href, 1'b0);
        chk("midrst_vsync", vsync, 1'b0);
        chk("midrst_dout", dout, 8'h00);
        chk("midrst_rd_en", rd_en, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        repeat (2) @(posedge pclk);
        #2 rst_n = 1'b1;
        repeat (FRAME + 10) @(posedge pclk);
        #2 en = 1'b0;
        repeat (FRAME) @(posedge pclk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
